fifo_beat_serializer: RTL and testbench

Reader-side companion to the team's register skid FIFO: drains wide words from a show-ahead FIFO read port (empty/q/rdreq) and writes each word as RATIO narrow beats into a downstream FIFO write port (wrreq/data/full). Sits between a wide datapath FIFO and a narrow link or narrow FIFO. Sustains one beat per cycle, with no bubble between words while input is available and the output is not full.

---
 rtl/fifo_serializer_pkg.sv | 16 +
 rtl/fifo_beat_serializer.sv | 85 ++++++++
 tb/tb_fifo_beat_serializer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_serializer_pkg.sv
// Shared types and helpers for the wide-to-narrow FIFO beat serializer.
package fifo_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Beat counter width; a RATIO of 1 still keeps a 1-bit counter.
    function automatic int unsigned beat_bits(input int unsigned ratio);
        int unsigned cb;
        cb = $clog2(ratio);
        return (cb < 1) ? 1 : cb;
    endfunction

endpackage

// File: rtl/fifo_beat_serializer.sv
// Drains wide words from a show-ahead FIFO and writes each one as RATIO narrow
// beats (LSB beat first) into a downstream FIFO write port.
module fifo_beat_serializer
    import fifo_serializer_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned RATIO     = 4,
    localparam int unsigned OUT_WIDTH = IN_WIDTH / RATIO
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_empty,
    input  logic [IN_WIDTH-1:0]  in_q,
    output logic                 in_rdreq,
    input  logic                 out_full,
    output logic                 out_wrreq,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic [31:0]          words_sent
);

    localparam int unsigned BW = beat_bits(RATIO);

    if (RATIO < 1 || RATIO > 256) begin : g_bad_ratio
        $error("fifo_beat_serializer: RATIO must be in 1..256");
    end else if (IN_WIDTH % RATIO != 0) begin : g_bad_width
        $error("fifo_beat_serializer: IN_WIDTH must be a multiple of RATIO");
    end

    ser_state_t          state_ff;
    logic [IN_WIDTH-1:0] hold_ff;
    logic [BW-1:0]       beat_ff;
    logic [31:0]         words_ff;

    logic held;
    logic fire_last;

    // Every output depends only on registers, out_full and in_empty.
    always_comb begin
        held       = (state_ff == SEND);
        out_wrreq  = held & ~out_full;
        out_data   = hold_ff[int'(beat_ff) * int'(OUT_WIDTH) +: OUT_WIDTH];
        out_last   = held & (beat_ff == BW'(RATIO - 1));
        fire_last  = out_wrreq & out_last;
        in_rdreq   = ~in_empty & (~held | fire_last);
        words_sent = words_ff;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_ff <= IDLE;
            hold_ff  <= '0;
            beat_ff  <= '0;
            words_ff <= '0;
        end else begin
            unique case (state_ff)
                IDLE: begin
                    if (in_rdreq) begin
                        hold_ff  <= in_q;
                        beat_ff  <= '0;
                        state_ff <= SEND;
                    end
                end
                SEND: begin
                    if (out_wrreq) begin
                        if (!out_last) begin
                            beat_ff <= beat_ff + 1'b1;
                        end else begin
                            // Popping on the final beat keeps words back-to-back.
                            words_ff <= words_ff + 32'd1;
                            beat_ff  <= '0;
                            if (in_rdreq) begin
                                hold_ff <= in_q;
                            end else begin
                                state_ff <= IDLE;
                            end
                        end
                    end
                end
                default: state_ff <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_beat_serializer.sv
// Scoreboard bench for fifo_beat_serializer: a RATIO=4 instance under directed and
// random traffic, plus a RATIO=1 instance for pass-through and counter wrap.
module tb_fifo_beat_serializer;

    localparam int unsigned IW = 32;
    localparam int unsigned R  = 4;
    localparam int unsigned OW = IW / R;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_empty;
    logic [IW-1:0] in_q;
    logic          in_rdreq;
    logic          out_full;
    logic          out_wrreq;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic [31:0]   words_sent;

    logic          e1;
    logic [31:0]   q1;
    logic          rd1;
    logic          full1;
    logic          wr1;
    logic [31:0]   d1;
    logic          last1;
    logic [31:0]   ws1;

    always #5 clock = ~clock;

    fifo_beat_serializer #(.IN_WIDTH(IW), .RATIO(R)) dut (
        .clock(clock), .reset_n(reset_n), .in_empty(in_empty), .in_q(in_q),
        .in_rdreq(in_rdreq), .out_full(out_full), .out_wrreq(out_wrreq),
        .out_data(out_data), .out_last(out_last), .words_sent(words_sent)
    );

    fifo_beat_serializer #(.IN_WIDTH(32), .RATIO(1)) u1 (
        .clock(clock), .reset_n(reset_n), .in_empty(e1), .in_q(q1),
        .in_rdreq(rd1), .out_full(full1), .out_wrreq(wr1),
        .out_data(d1), .out_last(last1), .words_sent(ws1)
    );

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [IW-1:0] src[$];

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    int            last_rd_cyc = 0;
    int            last_wr_cyc = 0;
    logic [OW-1:0] last_wr_data = '0;
    logic [31:0]   words_model = '0;
    int            full_pct = 0;
    int            gap_pct = 0;
    int            stall_left = 0;
    bit            stall_armed = 0;
    logic [OW-1:0] stall_on = '0;
    bit            mark_en = 0;
    logic [OW-1:0] mark_data = '0;
    int            mark_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Upstream/downstream stimulus, applied just after the active edge.
    always @(posedge clock) begin
        #1;
        in_empty = (src.size() == 0) || ($urandom_range(99) < gap_pct);
        in_q     = (src.size() != 0) ? src[0] : $urandom();
        if (stall_left > 0) begin
            out_full = 1'b1;
            stall_left--;
        end else begin
            out_full = ($urandom_range(99) < full_pct);
        end
    end

    // Monitor: pops the upstream model on each read, scores each written beat.
    always @(negedge clock) begin
        beat_t         b;
        logic [IW-1:0] w;
        cyc++;
        if (reset_n) begin
            check("rdreq_while_empty", 32'(in_rdreq & in_empty), 32'd0);
            check("wrreq_while_full", 32'(out_wrreq & out_full), 32'd0);
            check("words_sent", words_sent, words_model);
            if (out_wrreq) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", 32'(out_data), 32'(b.data));
                    check("beat_last", 32'(out_last), 32'(b.last));
                    if (b.last) words_model++;
                end
                wr_cnt++;
                last_wr_cyc  = cyc;
                last_wr_data = out_data;
                if (mark_en && out_data == mark_data) mark_cyc = cyc;
                if (stall_armed && out_data == stall_on) begin
                    stall_left  = 3;
                    stall_armed = 0;
                end
            end
            if (in_rdreq) begin
                if (src.size() == 0) begin
                    check("read_without_word", 32'(in_rdreq), 32'd0);
                end else begin
                    w = src.pop_front();
                    for (int k = 0; k < int'(R); k++) begin
                        exp_q.push_back('{data: w[k*OW +: OW], last: (k == int'(R) - 1)});
                    end
                end
                rd_cnt++;
                last_rd_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(negedge clock);
        #2;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((src.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(n >= budget), 32'd0);
        step();
    endtask

    initial begin
        int w0;
        int r0;
        int first_rd;
        reset_n  = 1'b0;
        in_empty = 1'b1;
        in_q     = '0;
        out_full = 1'b0;
        e1       = 1'b1;
        q1       = '0;
        full1    = 1'b0;
        #1;
        check("rst_in_rdreq", 32'(in_rdreq), 32'd0);
        check("rst_out_wrreq", 32'(out_wrreq), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_words_sent", words_sent, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Single word.
        w0 = wr_cnt;
        src.push_back(32'hDDCC_BBAA);
        wait_drain(50);
        check("single_beats", 32'(wr_cnt - w0), 32'd4);
        check("single_span", 32'(last_wr_cyc - last_rd_cyc), 32'd4);
        check("single_words", words_sent, 32'd1);

        // Back-to-back words.
        w0 = wr_cnt;
        r0 = rd_cnt;
        mark_en   = 1;
        mark_data = 8'h44;
        src.push_back(32'h4433_2211);
        src.push_back(32'h8877_6655);
        step();
        first_rd = last_rd_cyc;
        wait_drain(50);
        mark_en = 0;
        check("b2b_beats", 32'(wr_cnt - w0), 32'd8);
        check("b2b_no_gap", 32'(last_wr_cyc - first_rd), 32'd8);
        check("b2b_rdreq_pulses", 32'(rd_cnt - r0), 32'd2);
        check("b2b_rd_on_last", 32'(mark_cyc), 32'(last_rd_cyc));

        // Stall after beat 0xBB.
        w0 = wr_cnt;
        stall_on    = 8'hBB;
        stall_armed = 1;
        src.push_back(32'hDDCC_BBAA);
        for (int n = 0; n < 20 && stall_armed; n++) step();
        check("stall_reached", 32'(stall_armed), 32'd0);
        for (int n = 0; n < 3; n++) begin
            step();
            check("stall_full", 32'(out_full), 32'd1);
            check("stall_wrreq", 32'(out_wrreq), 32'd0);
            check("stall_data", 32'(out_data), 32'hCC);
        end
        wait_drain(50);
        check("stall_beats", 32'(wr_cnt - w0), 32'd4);

        // Empty gap between two words.
        src.push_back(32'h1357_9BDF);
        wait_drain(50);
        for (int n = 0; n < 5; n++) begin
            check("gap_wrreq", 32'(out_wrreq), 32'd0);
            check("gap_rdreq", 32'(in_rdreq), 32'd0);
            step();
        end
        mark_en   = 1;
        mark_data = 8'h5A;
        mark_cyc  = -1;
        src.push_back(32'h0102_035A);
        wait_drain(50);
        mark_en = 0;
        check("gap_latency", 32'(mark_cyc - last_rd_cyc), 32'd1);

        // Reset mid-word after beat 0xBB.
        src.push_back(32'hDDCC_BBAA);
        for (int n = 0; n < 20 && last_wr_data != 8'hBB; n++) step();
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        words_model = '0;
        check("midrst_in_rdreq", 32'(in_rdreq), 32'd0);
        check("midrst_out_wrreq", 32'(out_wrreq), 32'd0);
        check("midrst_out_last", 32'(out_last), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_words", words_sent, 32'd0);
        w0 = wr_cnt;
        step();
        step();
        reset_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            check("midrst_no_beats", 32'(out_wrreq), 32'd0);
        end
        check("midrst_beat_count", 32'(wr_cnt - w0), 32'd0);
        check("midrst_words_after", words_sent, 32'd0);

        // Random traffic with random upstream gaps and downstream backpressure.
        full_pct = 30;
        gap_pct  = 25;
        r0 = rd_cnt;
        for (int n = 0; n < 150; n++) src.push_back($urandom());
        wait_drain(6000);
        full_pct = 0;
        gap_pct  = 0;
        check("rand_words_popped", 32'(rd_cnt - r0), 32'd150);
        check("rand_words_sent", words_sent, 32'd150);

        // RATIO=1 pass-through and counter wrap.
        q1 = 32'h1234_5678;
        e1 = 1'b0;
        #1;
        check("r1_rdreq", 32'(rd1), 32'd1);
        step();
        e1 = 1'b1;
        #1;
        check("r1_wrreq", 32'(wr1), 32'd1);
        check("r1_data", d1, 32'h1234_5678);
        check("r1_last", 32'(last1), 32'd1);
        step();
        check("r1_idle", 32'(wr1), 32'd0);
        check("r1_words", ws1, 32'd1);
        force u1.words_ff = 32'hFFFF_FFFF;
        #1;
        release u1.words_ff;
        #1;
        check("r1_preload", ws1, 32'hFFFF_FFFF);
        q1 = 32'hCAFE_F00D;
        e1 = 1'b0;
        step();
        e1 = 1'b1;
        #1;
        check("r1_data2", d1, 32'hCAFE_F00D);
        step();
        check("r1_wrap", ws1, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
